tri_bus_arbiter: RTL



---
 rtl/tri_bus_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tri_bus_arbiter.sv
// Purpose : round-robin drive arbiter for a shared multi-driver net, with an all-off turnaround gap between owners.
// Latency : 1 cycle from req to grant in IDLE; the next owner is granted exactly TURN all-zero cycles after a release.
// Backpr. : an owner holding MAX_HOLD cycles is preempted only while another request is pending; a lone requester holds indefinitely.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   req     - level request per requester (not latched; dropping it before grant loses it)
//   grant   - registered one-hot-or-zero drive permission
//   owner   - registered index of current/last owner, held through GAP and IDLE
//   busy    - registered, equals OR of grant
//   preempt - registered one-cycle pulse during the first GAP cycle after a forced release
module tri_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     preempt
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_hold_cnt;
    logic [3:0]         r_gap_cnt;
    logic               r_busy;
    logic               r_preempt;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [7:0]         w_hold_nxt;
    logic [3:0]         w_gap_nxt;
    logic               w_preempt_nxt;

    logic               w_win_vld;
    logic [IDX_W-1:0]   w_win_idx;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [N_REQ-1:0]   w_owner_mask;
    logic               w_owner_req;
    logic               w_others_req;

    // (base + off) mod N_REQ for off < N_REQ; N_REQ need not be a power of 2,
    // so a single conditional subtract replaces bit truncation.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(32'(base)) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[IDX_W-1:0];
    endfunction

    // Round-robin search starting at r_ptr. Walking offsets from high to low
    // lets the lowest offset (closest to the pointer) overwrite the result.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(r_ptr, i)]) begin
                w_win_vld = 1'b1;
                w_win_idx = wrap_idx(r_ptr, i);
            end
        end
    end

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
        w_owner_mask            = '0;
        w_owner_mask[r_owner]   = 1'b1;
    end

    assign w_owner_req  = req[r_owner];
    assign w_others_req = |(req & ~w_owner_mask);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_preempt_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = w_win_onehot;
                    w_owner_nxt = w_win_idx;
                    w_ptr_nxt   = wrap_idx(w_win_idx, 1);
                    w_hold_nxt  = 8'd1;
                end
            end

            ST_OWN: begin
                // A dropped owner request takes priority over preemption, so a
                // coincident drop is a plain release without a preempt pulse.
                if (!w_owner_req) begin
                    w_state_nxt = ST_GAP;
                    w_grant_nxt = '0;
                    w_gap_nxt   = 4'(TURN);
                end else if ((r_hold_cnt >= 8'(MAX_HOLD)) && w_others_req) begin
                    w_state_nxt   = ST_GAP;
                    w_grant_nxt   = '0;
                    w_gap_nxt     = 4'(TURN);
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt < 8'(MAX_HOLD)) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end

            ST_GAP: begin
                // Last gap cycle: arbitrate directly so the next owner sees
                // exactly TURN all-zero cycles.
                if (r_gap_cnt == 4'd1) begin
                    w_gap_nxt = 4'd0;
                    if (w_win_vld) begin
                        w_state_nxt = ST_OWN;
                        w_grant_nxt = w_win_onehot;
                        w_owner_nxt = w_win_idx;
                        w_ptr_nxt   = wrap_idx(w_win_idx, 1);
                        w_hold_nxt  = 8'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_busy     <= |w_grant_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule
